// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter, pacing each byte by one full serial frame time.
// Latency: a byte written at edge k into an empty idle buffer shows byte_ready after edge k+1, t_byte after k+2.
// Backpressure: none toward the core; a write into a full buffer (no same-cycle pop) is dropped and sets sticky overflow.
module uart_tx_buffer #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 5208,
   parameter int FRAME_BITS   = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   byte_ready,
   output logic                   t_byte,
   output logic [7:0]             data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW         = $clog2(DEPTH);
   localparam int CW         = AW + 1;
   localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
   localparam int TW         = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CLKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_START = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [TW-1:0]   timer_q;
   logic            pop;
   logic            push;

   // Occupancy flags come straight from the registered counter.
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // A pop frees a slot in the same cycle, so a full buffer still accepts a write then.
   assign push  = wr_en && (!full || pop);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and one-cycle strobes; the pop happens only on the IDLE->LOAD step.
   always_comb begin
      state_d    = state_q;
      byte_ready = 1'b0;
      t_byte     = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            byte_ready = 1'b1;
            state_d    = ST_START;
         end
         ST_START: begin
            t_byte  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (timer_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame timer: loaded leaving START, counts down through WAIT, holds at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else if (state_q == ST_START) begin
         timer_q <= TIMER_LOAD;
      end else if (state_q == ST_WAIT && timer_q != '0) begin
         timer_q <= timer_q - TW'(1);
      end
   end

   // Storage array; written only on an accepted write, never bypassed to data.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy counter; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Output byte register: captures the head entry at the pop and holds until the next pop.
   always_ff @(posedge clk) begin
      if (rst)      data <= 8'h00;
      else if (pop) data <= mem[rd_ptr];
   end

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)                      overflow <= 1'b0;
      else if (wr_en && full && !pop) overflow <= 1'b1;
   end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO plus transmit pacer between the core's byte-write strobe and the UART transmitter.
- The core writes bytes at full clock rate. The block holds them and hands them to the UART one at a time, spaced by one full serial frame time.
- The UART returns no busy signal, so the block paces each byte with its own frame timer.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
CLKS_PER_BIT, 5208, clock cycles per serial bit; must match the UART baud divisor.
FRAME_BITS, 10, bits per frame (start + 8 data + stop).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  core write strobe; one byte per high cycle.
wr_data  input  8  byte from core, sampled when wr_en=1.
byte_ready  output  1  to UART; high for one cycle while data is valid (LOAD).
t_byte  output  1  to UART; one-cycle start-transmit pulse (START).
data  output  8  byte to UART; stable from LOAD through end of WAIT.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
count  output  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky; a write was dropped.

Behaviour:
- **Reset.** Synchronous, active-high. rst high at an edge sets:
  - byte_ready=0, t_byte=0, data=0, count=0, empty=1, full=0, overflow=0;
  - FSM=IDLE, read/write pointers=0, frame timer=0.
  - Reset mid-frame abandons the byte in flight and all queued bytes.
- **FIFO storage.** Circular buffer with wrapping pointers. count is a registered occupancy counter:
  - +1 on accepted write only;
  - -1 on pop only;
  - unchanged when both occur in the same cycle.
- **Write acceptance.**
  - Write accepted if !full, or if a pop occurs in the same cycle.
  - Write when full with no pop: byte dropped, count unchanged, overflow set to 1 until rst.
- **Pop.** Occurs only on the IDLE->LOAD transition. The head byte is registered into data at that edge.
- **FSM states and transitions:**
  - IDLE: outputs low. If !empty (registered count>0), pop and go to LOAD; otherwise stay.
  - LOAD: byte_ready=1 for exactly one cycle, data valid; next state START.
  - START: t_byte=1 for exactly one cycle; frame timer loaded with CLKS_PER_BIT*FRAME_BITS-1; next state WAIT.
  - WAIT: timer decrements each cycle; at 0, next state IDLE.
- **Latency.**
  - Write at edge k into an empty idle buffer: empty=0 after edge k; LOAD entered at edge k+1; byte_ready high in cycle k+1..k+2; t_byte high in cycle k+2..k+3.
  - Back-to-back queued bytes: byte_ready pulses spaced exactly CLKS_PER_BIT*FRAME_BITS+3 cycles apart.
- **Simultaneous events.**
  - Write in the same cycle the FSM pops the last entry: count stays 1 and the new byte is queued (not lost).
  - Write when empty is never bypassed to data; it always passes through FIFO storage.
- **Ordering.** Strict FIFO order; no byte duplicated or reordered.
- **Timer width.** $clog2(CLKS_PER_BIT*FRAME_BITS); the timer counts down with no wrap.

Test Plan:
- **Reset values.** CLKS_PER_BIT=4, FRAME_BITS=10; assert rst 2 cycles -> all outputs 0 except empty=1; FSM idle for 50 cycles with no writes (byte_ready never rises).
- **Single byte.** Write 0x41 at edge k -> byte_ready=1 only in cycle k+1, data=0x41; t_byte=1 only in cycle k+2; data holds 0x41 through WAIT; empty=1 from edge k+1.
- **Burst of 3.** Write 0x10, 0x20, 0x30 on consecutive cycles -> byte_ready pulses exactly 43 cycles apart with data 0x10, 0x20, 0x30 in order; count peaks at 2, then reaches 0.
- **Overflow.** DEPTH=4; write 0xA0..0xA5 back-to-back -> first byte popped, 4 queued, 6th dropped with overflow=1 and full=1. Outputs A0, A1, A2, A3, A4 in order; A5 never appears; overflow stays 1.
- **Write during last pop.** count=1; write 0x55 in the IDLE->LOAD cycle -> count remains 1; 0x55 transmitted next frame.
- **Reset mid-operation.** Assert rst during WAIT with 3 bytes queued -> next cycle FSM idle, count=0, empty=1, data=0. New write 0x77 is the next and only byte transmitted.
